hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forward selects, load-use/HI-LO stall, stall counter.
// Selects and Stall are combinational (zero latency); Stall holds PC/D and bubbles E.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_Tuse1,
    input  logic [1:0]  D_Tuse2,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [4:0]  W_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        D_MD,
    input  logic        E_MDStart,
    input  logic        E_MDDiv,
    input  logic [4:0]  E_A1,
    input  logic [4:0]  E_A2,
    input  logic [4:0]  M_A2,
    output logic        PC_Enable,
    output logic        RegD_Enable,
    output logic        RegE_Clr,
    output logic [2:0]  MFRD1D,
    output logic [2:0]  MFRD2D,
    output logic [2:0]  MFALUAE,
    output logic [2:0]  MFALUBE,
    output logic [2:0]  MFWDM,
    output logic        MD_Busy,
    output logic        Stall,
    output logic [15:0] StallCnt
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [3:0]  md_cnt;
    logic        reg_haz;
    logic [15:0] stall_cnt;

    // Priority E > M > W; a stage only forwards once its result is ready (Tnew == 0).
    function automatic logic [2:0] fwd_sel(
        input logic [4:0] addr,
        input logic       use_e,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        fwd_sel = 3'd0;
        if (addr != 5'd0) begin
            if (use_e && e_a3 == addr && e_tnew == 2'd0)
                fwd_sel = 3'd3;
            else if (m_a3 == addr && m_tnew == 2'd0)
                fwd_sel = 3'd2;
            else if (w_a3 == addr)
                fwd_sel = 3'd1;
        end
    endfunction

    function automatic logic op_haz(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        op_haz = 1'b0;
        if (addr != 5'd0) begin
            if (e_a3 == addr && tuse < e_tnew)
                op_haz = 1'b1;
            if (m_a3 == addr && tuse < m_tnew)
                op_haz = 1'b1;
        end
    endfunction

    always_comb begin
        MFRD1D  = fwd_sel(D_A1, 1'b1, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        MFRD2D  = fwd_sel(D_A2, 1'b1, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        MFALUAE = fwd_sel(E_A1, 1'b0, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        MFALUBE = fwd_sel(E_A2, 1'b0, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        MFWDM   = (W_A3 != 5'd0 && W_A3 == M_A2) ? 3'd1 : 3'd0;
    end

    assign reg_haz = op_haz(D_A1, D_Tuse1, E_A3, E_Tnew, M_A3, M_Tnew) |
                     op_haz(D_A2, D_Tuse2, E_A3, E_Tnew, M_A3, M_Tnew);

    // The start cycle itself counts as busy so the counter only needs to cover t+1..t+N.
    assign MD_Busy     = E_MDStart | (md_cnt != 4'd0);
    assign Stall       = reg_haz | (D_MD & MD_Busy);
    assign PC_Enable   = ~Stall;
    assign RegD_Enable = ~Stall;
    assign RegE_Clr    = Stall;
    assign StallCnt    = stall_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            md_cnt <= 4'd0;
        end else if (E_MDStart) begin
            md_cnt <= E_MDDiv ? DIV_LD : MULT_LD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= 16'd0;
        end else if (Stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, HI/LO busy timing, stall counter.
module tb_hazard_ctrl;

    logic        Clk;
    logic        Reset;
    logic [4:0]  D_A1, D_A2;
    logic [1:0]  D_Tuse1, D_Tuse2;
    logic [4:0]  E_A3, M_A3, W_A3;
    logic [1:0]  E_Tnew, M_Tnew;
    logic        D_MD, E_MDStart, E_MDDiv;
    logic [4:0]  E_A1, E_A2, M_A2;
    logic        PC_Enable, RegD_Enable, RegE_Clr;
    logic [2:0]  MFRD1D, MFRD2D, MFALUAE, MFALUBE, MFWDM;
    logic        MD_Busy, Stall;
    logic [15:0] StallCnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk(Clk), .Reset(Reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
        .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .D_MD(D_MD), .E_MDStart(E_MDStart), .E_MDDiv(E_MDDiv),
        .E_A1(E_A1), .E_A2(E_A2), .M_A2(M_A2),
        .PC_Enable(PC_Enable), .RegD_Enable(RegD_Enable), .RegE_Clr(RegE_Clr),
        .MFRD1D(MFRD1D), .MFRD2D(MFRD2D), .MFALUAE(MFALUAE), .MFALUBE(MFALUBE),
        .MFWDM(MFWDM), .MD_Busy(MD_Busy), .Stall(Stall), .StallCnt(StallCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        D_A1 = 0; D_A2 = 0; D_Tuse1 = 2'd3; D_Tuse2 = 2'd3;
        E_A3 = 0; M_A3 = 0; W_A3 = 0; E_Tnew = 0; M_Tnew = 0;
        D_MD = 0; E_MDStart = 0; E_MDDiv = 0;
        E_A1 = 0; E_A2 = 0; M_A2 = 0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b0;
        #2;
        check("rst_stallcnt", 32'(StallCnt), 0);
        check("rst_busy", 32'(MD_Busy), 0);
        check("rst_pc_en", 32'(PC_Enable), 1);
        check("rst_fwd1", 32'(MFRD1D), 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Load-use hazard on rs, then resolved by E forwarding
        E_A3 = 8; E_Tnew = 1; D_A1 = 8; D_Tuse1 = 0;
        #1;
        check("s1_stall", 32'(Stall), 1);
        check("s1_pc_en", 32'(PC_Enable), 0);
        check("s1_regd_en", 32'(RegD_Enable), 0);
        check("s1_rege_clr", 32'(RegE_Clr), 1);
        check("s1_fwd_notready", 32'(MFRD1D), 0);
        E_Tnew = 0;
        #1;
        check("s1_nostall", 32'(Stall), 0);
        check("s1_fwd_e", 32'(MFRD1D), 3);

        // Forward priority on rt
        idle_inputs();
        E_A3 = 5; M_A3 = 5; W_A3 = 5; D_A2 = 5;
        #1;
        check("s2_prio_e", 32'(MFRD2D), 3);
        E_A3 = 0;
        #1;
        check("s2_prio_m", 32'(MFRD2D), 2);
        M_Tnew = 1;
        #1;
        check("s2_prio_w", 32'(MFRD2D), 1);
        D_Tuse2 = 0;
        #1;
        check("s2_m_haz", 32'(Stall), 1);
        D_Tuse2 = 2'd3; M_Tnew = 0; D_A2 = 0;
        #1;
        check("s2_zero_addr", 32'(MFRD2D), 0);
        check("s2_no_stall", 32'(Stall), 0);

        // ALU operand forwarding never selects E
        idle_inputs();
        E_A3 = 7; M_A3 = 9; W_A3 = 7; E_A1 = 9; E_A2 = 7;
        #1;
        check("alu_a_m", 32'(MFALUAE), 2);
        check("alu_b_w", 32'(MFALUBE), 1);
        W_A3 = 0;
        #1;
        check("alu_b_no_e", 32'(MFALUBE), 0);

        // Store-data forwarding
        idle_inputs();
        M_A2 = 3; W_A3 = 3;
        #1;
        check("s6_wdm", 32'(MFWDM), 1);
        W_A3 = 0;
        #1;
        check("s6_wdm_zero", 32'(MFWDM), 0);

        // Divide busy window t..t+10
        idle_inputs();
        @(negedge Clk);
        E_MDStart = 1; E_MDDiv = 1; D_MD = 1;
        #1;
        check("s3_stall_t0", 32'(Stall), 1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            E_MDStart = 0; E_MDDiv = 0;
            #1;
            check($sformatf("s3_stall_t%0d", i), 32'(Stall), 1);
        end
        @(negedge Clk);
        #1;
        check("s3_stall_t11", 32'(Stall), 0);

        // Multiply then divide restart at counter==2: busy through t+14
        idle_inputs();
        @(negedge Clk);
        E_MDStart = 1; E_MDDiv = 0;
        @(negedge Clk);
        E_MDStart = 0;
        repeat (3) @(negedge Clk);
        E_MDStart = 1; E_MDDiv = 1;
        #1;
        check("s4_busy_restart", 32'(MD_Busy), 1);
        for (int i = 5; i <= 14; i++) begin
            @(negedge Clk);
            E_MDStart = 0; E_MDDiv = 0;
            #1;
            check($sformatf("s4_busy_t%0d", i), 32'(MD_Busy), 1);
        end
        @(negedge Clk);
        #1;
        check("s4_busy_t15", 32'(MD_Busy), 0);

        // Stall counter: count, saturate, asynchronous clear
        idle_inputs();
        @(negedge Clk);
        Reset = 0;
        #1;
        check("s5_clear0", 32'(StallCnt), 0);
        Reset = 1;
        E_A3 = 8; E_Tnew = 1; D_A1 = 8; D_Tuse1 = 0;
        repeat (100) @(negedge Clk);
        #1;
        check("s5_cnt100", 32'(StallCnt), 100);
        repeat (69900) @(negedge Clk);
        #1;
        check("s5_saturate", 32'(StallCnt), 32'hFFFF);
        @(negedge Clk);
        E_MDStart = 1; E_MDDiv = 1;
        @(negedge Clk);
        E_MDStart = 0; E_MDDiv = 0;
        #1;
        check("s5_md_busy", 32'(MD_Busy), 1);
        check("s5_hold_sat", 32'(StallCnt), 32'hFFFF);
        #1;
        Reset = 0;
        #1;
        check("s5_rst_cnt", 32'(StallCnt), 0);
        check("s5_rst_busy", 32'(MD_Busy), 0);
        check("s5_rst_stall_comb", 32'(Stall), 1);
        @(negedge Clk);
        #1;
        check("s5_rst_hold", 32'(StallCnt), 0);
        Reset = 1;
        #1;
        check("s5_release_nochg", 32'(StallCnt), 0);
        @(negedge Clk);
        #1;
        check("s5_after_release", 32'(StallCnt), 1);
        check("s5_busy_aborted", 32'(MD_Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
